// File: rtl/rcv_frame_ctrl.sv
// Serial receive framing controller: start-bit validation, LSB-first data capture,
// stop-bit check and consumer handshake with overrun/framing status.
module rcv_frame_ctrl #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 start_bit_detected,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int TW = $clog2(BIT_PERIOD);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_TERM = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [TW-1:0] FULL_TERM = TW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   ready_q, ready_d;
    logic                   overrun_q, overrun_d;
    logic                   framing_q, framing_d;
    logic                   sync_in;

    assign sync_in = sync2_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        sync1_d   = serial_in;
        sync2_d   = sync1_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        framing_d = framing_q;

        // A read outside LOAD acknowledges the pending word; LOAD below overrides it.
        if (data_read) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_bit_detected) begin
                    state_d   = START_CHK;
                    timer_d   = '0;
                    idx_d     = '0;
                    framing_d = 1'b0;
                end
            end
            START_CHK: begin
                if (timer_q == HALF_TERM) begin
                    timer_d = '0;
                    state_d = sync_in ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == FULL_TERM) begin
                    timer_d = '0;
                    shift_d = {sync_in, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_q == FULL_TERM) begin
                    timer_d = '0;
                    if (sync_in) begin
                        state_d = LOAD;
                    end else begin
                        framing_d = 1'b1;
                        shift_d   = '0;
                        state_d   = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOAD: begin
                rx_data_d = shift_q;
                ready_d   = 1'b1;
                if (data_read) begin
                    overrun_d = 1'b0;
                end else if (ready_q) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            shift_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl: good frames, glitch rejection, framing error,
// overrun, read-on-load and mid-frame reset, all with hand-computed expectations.
module tb_rcv_frame_ctrl;

    localparam int BP = 10;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic          start_bit_detected;
    logic          data_read;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;

    int   checks = 0;
    int   errors = 0;
    logic drAt95, drAt96, feAt0;

    rcv_frame_ctrl #(.BIT_PERIOD(BP), .DATA_BITS(DB)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .serial_in          (serial_in),
        .start_bit_detected (start_bit_detected),
        .data_read          (data_read),
        .rx_data            (rx_data),
        .data_ready         (data_ready),
        .overrun_error      (overrun_error),
        .framing_error      (framing_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called just after a rising edge; the start pulse is taken at the next edge (edge 0).
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic readOnLoad, input int nCycles);
        int nextBit;
        serial_in          = 1'b0;
        start_bit_detected = 1'b1;
        for (int cyc = 0; cyc < nCycles; cyc++) begin
            @(posedge clk); #1;
            start_bit_detected = 1'b0;
            if (cyc == 0)  feAt0  = framing_error;
            if (cyc == 95) drAt95 = data_ready;
            if (cyc == 96) drAt96 = data_ready;
            nextBit = (cyc + 1) / BP;
            if (nextBit == 0)           serial_in = 1'b0;
            else if (nextBit <= DB)     serial_in = data[nextBit-1];
            else if (nextBit == DB + 1) serial_in = stopBit;
            else                        serial_in = 1'b1;
            data_read = readOnLoad && (cyc + 1 == 96);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic readPulse();
        data_read = 1'b1;
        @(posedge clk); #1;
        data_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        n_rst              = 1'b1;
        serial_in          = 1'b1;
        start_bit_detected = 1'b0;
        data_read          = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("reset_rx_data", 32'(rx_data), 32'h0);
        checkOutput("reset_data_ready", 32'(data_ready), 32'h0);
        checkOutput("reset_overrun", 32'(overrun_error), 32'h0);
        checkOutput("reset_framing", 32'(framing_error), 32'h0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        idleCycles(2);

        // Good frame with exact 96-clock latency
        applyStimulus(8'hA5, 1'b1, 1'b0, 100);
        checkOutput("a5_ready_at_95", 32'(drAt95), 32'h0);
        checkOutput("a5_ready_at_96", 32'(drAt96), 32'h1);
        checkOutput("a5_rx_data", 32'(rx_data), 32'hA5);
        checkOutput("a5_overrun", 32'(overrun_error), 32'h0);
        checkOutput("a5_framing", 32'(framing_error), 32'h0);
        readPulse();
        checkOutput("a5_read_ready", 32'(data_ready), 32'h0);
        checkOutput("a5_read_rx_data", 32'(rx_data), 32'hA5);

        // Two-clock low glitch; block must be back in IDLE for a pulse 6 clocks later
        serial_in          = 1'b0;
        start_bit_detected = 1'b1;
        @(posedge clk); #1;
        start_bit_detected = 1'b0;
        @(posedge clk); #1;
        serial_in = 1'b1;
        idleCycles(4);
        checkOutput("glitch_ready", 32'(data_ready), 32'h0);
        checkOutput("glitch_framing", 32'(framing_error), 32'h0);
        applyStimulus(8'h5A, 1'b1, 1'b0, 100);
        checkOutput("post_glitch_ready_at_95", 32'(drAt95), 32'h0);
        checkOutput("post_glitch_ready_at_96", 32'(drAt96), 32'h1);
        checkOutput("post_glitch_rx_data", 32'(rx_data), 32'h5A);
        readPulse();

        // Framing error, then recovery
        applyStimulus(8'h3C, 1'b0, 1'b0, 100);
        checkOutput("fe_framing", 32'(framing_error), 32'h1);
        checkOutput("fe_ready", 32'(data_ready), 32'h0);
        checkOutput("fe_rx_data", 32'(rx_data), 32'h5A);
        applyStimulus(8'h81, 1'b1, 1'b0, 100);
        checkOutput("fe_cleared_on_start", 32'(feAt0), 32'h0);
        checkOutput("81_rx_data", 32'(rx_data), 32'h81);
        checkOutput("81_ready", 32'(data_ready), 32'h1);
        checkOutput("81_framing", 32'(framing_error), 32'h0);
        readPulse();

        // Overrun
        applyStimulus(8'h11, 1'b1, 1'b0, 100);
        checkOutput("11_overrun", 32'(overrun_error), 32'h0);
        applyStimulus(8'h22, 1'b1, 1'b0, 100);
        checkOutput("ovr_rx_data", 32'(rx_data), 32'h22);
        checkOutput("ovr_ready", 32'(data_ready), 32'h1);
        checkOutput("ovr_flag", 32'(overrun_error), 32'h1);
        readPulse();
        checkOutput("ovr_read_ready", 32'(data_ready), 32'h0);
        checkOutput("ovr_read_flag", 32'(overrun_error), 32'h0);

        // Read coincident with LOAD
        applyStimulus(8'h11, 1'b1, 1'b0, 100);
        applyStimulus(8'h55, 1'b1, 1'b1, 100);
        checkOutput("rol_rx_data", 32'(rx_data), 32'h55);
        checkOutput("rol_ready", 32'(data_ready), 32'h1);
        checkOutput("rol_overrun", 32'(overrun_error), 32'h0);

        // Framing error while data pending leaves the pending word alone
        applyStimulus(8'h77, 1'b1, 1'b0, 100);
        checkOutput("77_overrun", 32'(overrun_error), 32'h1);
        applyStimulus(8'h3C, 1'b0, 1'b0, 100);
        checkOutput("fe2_framing", 32'(framing_error), 32'h1);
        checkOutput("fe2_ready", 32'(data_ready), 32'h1);
        checkOutput("fe2_rx_data", 32'(rx_data), 32'h77);

        // Reset during data bit 4
        applyStimulus(8'hFF, 1'b1, 1'b0, 55);
        n_rst = 1'b0;
        #1;
        checkOutput("mid_rst_rx_data", 32'(rx_data), 32'h0);
        checkOutput("mid_rst_ready", 32'(data_ready), 32'h0);
        checkOutput("mid_rst_overrun", 32'(overrun_error), 32'h0);
        checkOutput("mid_rst_framing", 32'(framing_error), 32'h0);
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        idleCycles(60);
        checkOutput("post_rst_idle_ready", 32'(data_ready), 32'h0);
        applyStimulus(8'hF0, 1'b1, 1'b0, 100);
        checkOutput("f0_ready_at_96", 32'(drAt96), 32'h1);
        checkOutput("f0_rx_data", 32'(rx_data), 32'hF0);
        checkOutput("f0_ready", 32'(data_ready), 32'h1);
        checkOutput("f0_overrun", 32'(overrun_error), 32'h0);
        checkOutput("f0_framing", 32'(framing_error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcv_frame_ctrl.md
RCV_FRAME_CTRL -- requirements
Module: rcv_frame_ctrl

Interface
REQ-001 Parameter: BIT_PERIOD, default 10, clocks per serial bit; legal range 4..1023.
REQ-002 Parameter: DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: n_rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: serial_in  input  1  raw asynchronous serial line; idle 1.
REQ-006 Port: start_bit_detected  input  1  single-cycle falling-edge pulse from startbit_detect.
REQ-007 Port: data_read  input  1  consumer acknowledge; clears data_ready.
REQ-008 Port: rx_data  output  DATA_BITS  last good frame payload, LSB = first bit received.
REQ-009 Port: data_ready  output  1  rx_data holds unread valid data.
REQ-010 Port: overrun_error  output  1  a frame arrived while data_ready was 1.
REQ-011 Port: framing_error  output  1  last frame had stop bit sampled 0.

Function
REQ-012 serial_in SHALL pass through an internal 2-flop synchronizer (reset value 1); all samples use its output (sync_in).
REQ-013 FSM states: IDLE, START_CHK, DATA, STOP, LOAD.
REQ-014 IDLE: start_bit_detected=1 -> START_CHK, bit-timer cleared to 0, bit index cleared to 0; framing_error cleared in the same edge.
REQ-015 Bit-timer counts +1 per clock in START_CHK/DATA/STOP; sample point = timer reaching terminal value, then timer reloads to 0.
REQ-016 START_CHK terminal value = BIT_PERIOD/2 - 1 (integer division); sync_in=0 -> DATA; sync_in=1 -> IDLE (glitch rejected, no flag set).
REQ-017 DATA terminal value = BIT_PERIOD-1; at each sample, sync_in shifted into a DATA_BITS shift register from MSB side (LSB-first line order); bit index +1.
REQ-018 DATA -> STOP at the sample where bit index reaches DATA_BITS-1.
REQ-019 STOP terminal value = BIT_PERIOD-1; sync_in=1 -> LOAD; sync_in=0 -> framing_error=1, shift register discarded, -> IDLE.
REQ-020 LOAD lasts exactly one clock: rx_data <= shift register, data_ready <= 1, overrun_error <= 1 if data_ready was 1 and data_read=0 that cycle; -> IDLE.
REQ-021 Overrun: new frame overwrites rx_data; old data is lost.
REQ-022 data_read=1 with no LOAD that cycle: data_ready <= 0, overrun_error <= 0.
REQ-023 data_read=1 coincident with LOAD: load wins; data_ready stays 1, overrun_error <= 0.
REQ-024 start_bit_detected outside IDLE SHALL be ignored.
REQ-025 Total latency: data_ready rises (BIT_PERIOD/2) + (DATA_BITS+1)*BIT_PERIOD + 1 clocks after the start_bit_detected pulse cycle.
REQ-026 framing_error is sticky until next accepted start bit or reset; it never alters data_ready or rx_data.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 n_rst=0 SHALL asynchronously force: FSM IDLE, timer 0, bit index 0, synchronizer flops 1, shift register 0, rx_data 0, data_ready 0, overrun_error 0, framing_error 0.
REQ-029 Reset mid-frame SHALL abort the frame; after release the block waits in IDLE for a new start_bit_detected.

Verification (BIT_PERIOD=10, DATA_BITS=8)
REQ-030 Frame 0xA5 with stop=1 driven on serial_in, start pulse supplied -> rx_data=0xA5, data_ready=1 exactly 96 clocks after the pulse, flags 0.
REQ-031 Low glitch of 2 clocks then idle, start pulse supplied -> returns to IDLE after 5 clocks; data_ready, framing_error stay 0.
REQ-032 Frame 0x3C with stop=0 -> framing_error=1, data_ready=0, rx_data unchanged; next good frame 0x81 clears framing_error on its start pulse and loads 0x81.
REQ-033 Two frames 0x11, 0x22 with no data_read -> rx_data=0x22, data_ready=1, overrun_error=1; data_read pulse -> both 0 next clock.
REQ-034 data_read asserted on the LOAD cycle of frame 0x55 while 0x11 pending -> rx_data=0x55, data_ready=1, overrun_error=0.
REQ-035 n_rst asserted during data bit 4 of a frame -> all outputs 0 immediately; after release, full frame 0xF0 received correctly.
